// File: rtl/air_hockey_pkg.sv
// rtl/air_hockey_pkg.sv - table geometry, serve position and puck state shared by the puck blocks
package air_hockey_pkg;

  localparam int X_MIN     = 44;
  localparam int X_MAX     = 979;
  localparam int Y_MIN     = 44;
  localparam int Y_MAX     = 725;
  localparam int GOAL_Y_LO = 265;
  localparam int GOAL_Y_HI = 451;
  localparam int X_CENTER  = 487;
  localparam int Y_CENTER  = 362;

  typedef enum logic [1:0] {PLAY, HOLD, OVER} puck_state_t;

  // Friction: pull a velocity component one step toward zero.
  function automatic logic signed [4:0] vel_decay(input logic signed [4:0] v);
    if (v > 5'sd0) return v - 5'sd1;
    else if (v < 5'sd0) return v + 5'sd1;
    else return v;
  endfunction

endpackage

// File: rtl/puck_collide_chk.sv
// rtl/puck_collide_chk.sv - squared-distance overlap test between two circles of radius RADIUS_A and RADIUS_B
module puck_collide_chk #(
  parameter int RADIUS_A = 10,
  parameter int RADIUS_B = 20
) (
  input  logic [11:0] i_xa,
  input  logic [11:0] i_ya,
  input  logic [11:0] i_xb,
  input  logic [11:0] i_yb,
  output logic        o_hit
);

  localparam logic [26:0] LIMIT = 27'((RADIUS_A + RADIUS_B) * (RADIUS_A + RADIUS_B));

  logic signed [25:0] w_dx;
  logic signed [25:0] w_dy;
  logic        [26:0] w_sum;

  assign w_dx  = 26'(signed'({1'b0, i_xa})) - 26'(signed'({1'b0, i_xb}));
  assign w_dy  = 26'(signed'({1'b0, i_ya})) - 26'(signed'({1'b0, i_yb}));
  assign w_sum = 27'(unsigned'(w_dx * w_dx)) + 27'(unsigned'(w_dy * w_dy));
  assign o_hit = (w_sum < LIMIT);

endmodule

// File: rtl/puck_physics_ctl.sv
// rtl/puck_physics_ctl.sv - per-frame signed-velocity puck model with walls, mallet hits, friction, goals and scoring
module puck_physics_ctl
  import air_hockey_pkg::*;
#(
  parameter int RADIUS_BALL     = 10,
  parameter int PLAYERS_RADIUS  = 20,
  parameter int HIT_SPEED       = 4,
  parameter int MAX_SPEED       = 7,
  parameter int FRICTION_FRAMES = 16,
  parameter int HOLD_FRAMES     = 60,
  parameter int WIN_SCORE       = 7,
  parameter int SCORE_W         = 5
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [11:0]        xpos_player_1,
  input  logic [11:0]        ypos_player_1,
  input  logic [11:0]        xpos_player_2,
  input  logic [11:0]        ypos_player_2,
  output logic [11:0]        xpos_ball,
  output logic [11:0]        ypos_ball,
  output logic [SCORE_W-1:0] player_1_score,
  output logic [SCORE_W-1:0] player_2_score,
  output logic               goal_pulse,
  output logic               game_over
);

  localparam int FW      = $clog2(FRICTION_FRAMES + 1);
  localparam int HW      = $clog2(HOLD_FRAMES + 1);
  localparam int HIT_MAG = (HIT_SPEED > MAX_SPEED) ? MAX_SPEED : HIT_SPEED;

  localparam logic signed [4:0]  V_HIT = 5'(HIT_MAG);
  localparam logic signed [12:0] LX_LO = 13'(X_MIN + RADIUS_BALL);
  localparam logic signed [12:0] LX_HI = 13'(X_MAX - RADIUS_BALL);
  localparam logic signed [12:0] LY_LO = 13'(Y_MIN + RADIUS_BALL);
  localparam logic signed [12:0] LY_HI = 13'(Y_MAX - RADIUS_BALL);
  localparam logic signed [12:0] MOUTH_LO = 13'(GOAL_Y_LO + RADIUS_BALL);
  localparam logic signed [12:0] MOUTH_HI = 13'(GOAL_Y_HI - RADIUS_BALL);
  localparam logic [11:0]        CX = 12'(X_CENTER);
  localparam logic [11:0]        CY = 12'(Y_CENTER);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  puck_state_t         r_state, w_state_nx;
  logic [11:0]         r_x, r_y, w_x_nx, w_y_nx;
  logic signed [4:0]   r_vx, r_vy, w_vx_nx, w_vy_nx;
  logic [FW-1:0]       r_fric, w_fric_nx;
  logic [HW-1:0]       r_hold, w_hold_nx;
  logic [SCORE_W-1:0]  r_s1, r_s2, w_s1_nx, w_s2_nx;
  logic                r_goal, w_goal_nx;
  logic                r_over, w_over_nx;

  logic signed [12:0]  w_nx, w_ny;
  logic signed [4:0]   w_vx_ref, w_vy_ref;
  logic                w_mouth, w_goal_l, w_goal_r, w_wall_x, w_wall_y, w_wall;
  logic                w_hit_p1, w_hit_p2, w_fric_wrap;

  assign w_nx = signed'({1'b0, r_x}) + 13'(r_vx);
  assign w_ny = signed'({1'b0, r_y}) + 13'(r_vy);

  // Left-wall overlap inside the mouth is always a goal, so walls never fire there.
  assign w_mouth     = (w_ny > MOUTH_LO) && (w_ny < MOUTH_HI);
  assign w_goal_l    = (w_nx <= LX_LO) && w_mouth;
  assign w_goal_r    = (w_nx >= LX_HI) && w_mouth;
  assign w_wall_x    = (w_nx < LX_LO) || (w_nx > LX_HI);
  assign w_wall_y    = (w_ny < LY_LO) || (w_ny > LY_HI);
  assign w_wall      = w_wall_x || w_wall_y;
  assign w_vx_ref    = w_wall_x ? -r_vx : r_vx;
  assign w_vy_ref    = w_wall_y ? -r_vy : r_vy;
  assign w_fric_wrap = (r_fric == FW'(FRICTION_FRAMES - 1));

  puck_collide_chk #(.RADIUS_A(RADIUS_BALL), .RADIUS_B(PLAYERS_RADIUS)) u_hit_p1 (
    .i_xa(w_nx[11:0]), .i_ya(w_ny[11:0]),
    .i_xb(xpos_player_1), .i_yb(ypos_player_1), .o_hit(w_hit_p1)
  );

  puck_collide_chk #(.RADIUS_A(RADIUS_BALL), .RADIUS_B(PLAYERS_RADIUS)) u_hit_p2 (
    .i_xa(w_nx[11:0]), .i_ya(w_ny[11:0]),
    .i_xb(xpos_player_2), .i_yb(ypos_player_2), .o_hit(w_hit_p2)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= PLAY;
      r_x     <= CX;
      r_y     <= CY;
      r_vx    <= '0;
      r_vy    <= '0;
      r_fric  <= '0;
      r_hold  <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_goal  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_vx    <= w_vx_nx;
      r_vy    <= w_vy_nx;
      r_fric  <= w_fric_nx;
      r_hold  <= w_hold_nx;
      r_s1    <= w_s1_nx;
      r_s2    <= w_s2_nx;
      r_goal  <= w_goal_nx;
      r_over  <= w_over_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_vx_nx    = r_vx;
    w_vy_nx    = r_vy;
    w_fric_nx  = r_fric;
    w_hold_nx  = r_hold;
    w_s1_nx    = r_s1;
    w_s2_nx    = r_s2;
    w_goal_nx  = 1'b0;
    w_over_nx  = r_over;
    case (r_state)
      PLAY: if (frame_tick) begin
        w_fric_nx = w_fric_wrap ? '0 : r_fric + 1'b1;
        if (w_goal_l || w_goal_r) begin
          w_goal_nx  = 1'b1;
          w_hold_nx  = '0;
          w_state_nx = HOLD;
          if (w_goal_l) begin
            if (r_s2 != WIN) w_s2_nx = r_s2 + 1'b1;
          end else if (r_s1 != WIN) begin
            w_s1_nx = r_s1 + 1'b1;
          end
        end else if (!w_wall && w_hit_p1) begin
          w_vx_nx = (r_x >= xpos_player_1) ? V_HIT : -V_HIT;
          w_vy_nx = (r_y >= ypos_player_1) ? V_HIT : -V_HIT;
        end else if (!w_wall && w_hit_p2) begin
          w_vx_nx = (r_x >= xpos_player_2) ? V_HIT : -V_HIT;
          w_vy_nx = (r_y >= ypos_player_2) ? V_HIT : -V_HIT;
        end else begin
          // Free move; an offending axis is clamped to its wall and reflected.
          w_x_nx  = (w_nx < LX_LO) ? LX_LO[11:0] : (w_nx > LX_HI) ? LX_HI[11:0] : w_nx[11:0];
          w_y_nx  = (w_ny < LY_LO) ? LY_LO[11:0] : (w_ny > LY_HI) ? LY_HI[11:0] : w_ny[11:0];
          w_vx_nx = w_fric_wrap ? vel_decay(w_vx_ref) : w_vx_ref;
          w_vy_nx = w_fric_wrap ? vel_decay(w_vy_ref) : w_vy_ref;
        end
      end
      HOLD: if (frame_tick) begin
        if (r_hold == HW'(HOLD_FRAMES - 1)) begin
          w_hold_nx = '0;
          w_x_nx    = CX;
          w_y_nx    = CY;
          w_vx_nx   = '0;
          w_vy_nx   = '0;
          if ((r_s1 == WIN) || (r_s2 == WIN)) begin
            w_state_nx = OVER;
            w_over_nx  = 1'b1;
          end else begin
            w_state_nx = PLAY;
          end
        end else begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      OVER: begin
        w_x_nx    = CX;
        w_y_nx    = CY;
        w_vx_nx   = '0;
        w_vy_nx   = '0;
        w_over_nx = 1'b1;
      end
      default: w_state_nx = PLAY;
    endcase
  end

  assign xpos_ball      = r_x;
  assign ypos_ball      = r_y;
  assign player_1_score = r_s1;
  assign player_2_score = r_s2;
  assign goal_pulse     = r_goal;
  assign game_over      = r_over;

endmodule

// File: tb/tb_puck_physics_ctl.sv
// tb/tb_puck_physics_ctl.sv - directed checks of puck motion, walls, mallet hits, goals, hold and win state
module tb_puck_physics_ctl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [11:0] xp1, yp1, xp2, yp2;
  logic [11:0] xb, yb;
  logic [4:0]  s1, s2;
  logic        goal_pulse, game_over;

  int n_vec = 0;
  int n_bad = 0;
  int bx, by, my;

  always #5 clk_in = ~clk_in;

  puck_physics_ctl dut (
    .clk_in(clk_in), .rst(rst), .frame_tick(frame_tick),
    .xpos_player_1(xp1), .ypos_player_1(yp1),
    .xpos_player_2(xp2), .ypos_player_2(yp2),
    .xpos_ball(xb), .ypos_ball(yb),
    .player_1_score(s1), .player_2_score(s2),
    .goal_pulse(goal_pulse), .game_over(game_over)
  );

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check_val({tag, ".x"}, int'(xb), x);
    check_val({tag, ".y"}, int'(yb), y);
  endtask

  task automatic set_mallets(input int x1, input int y1, input int x2, input int y2);
    xp1 = 12'(x1);
    yp1 = 12'(y1);
    xp2 = 12'(x2);
    yp2 = 12'(y2);
  endtask

  task automatic park();
    set_mallets(100, 60, 900, 60);
  endtask

  // One frame pulse; returns at the falling edge right after the update edge.
  task automatic frame();
    @(negedge clk_in);
    frame_tick = 1'b1;
    @(negedge clk_in);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    park();
    @(negedge clk_in);
    do_reset();
    check_ball("reset", 487, 362);
    check_val("reset.s1", int'(s1), 0);
    check_val("reset.s2", int'(s2), 0);
    check_val("reset.over", int'(game_over), 0);
    check_val("reset.goal", int'(goal_pulse), 0);

    // Mallet 1 hit from the left, then free flight and first friction step
    set_mallets(460, 362, 900, 60);
    frame();
    check_ball("hit.still", 487, 362);
    frame();
    check_ball("hit.t2", 491, 366);
    repeat (14) frame();
    check_ball("hit.t16", 547, 422);
    frame();
    check_ball("hit.fric", 550, 425);

    // Both mallets touching: player 1 sign rule wins
    do_reset();
    set_mallets(477, 372, 497, 352);
    frame();
    check_ball("both.still", 487, 362);
    park();
    frame();
    check_ball("both.move", 491, 358);

    // Mallet 2 alone
    do_reset();
    set_mallets(100, 60, 497, 352);
    frame();
    park();
    frame();
    check_ball("p2.move", 483, 366);

    // Drive down to the bottom wall and bounce
    do_reset();
    park();
    frame();
    check_ball("bounce.idle", 487, 362);
    for (int k = 0; k < 88; k++) begin
      set_mallets(487 + 4 * k, 342 + 4 * k, 900, 60);
      frame();
      park();
      frame();
    end
    check_ball("bounce.pre", 839, 714);
    frame();
    check_ball("bounce.clamp", 843, 715);
    frame();
    check_ball("bounce.up", 847, 711);

    // Zigzag left into the goal mouth: point for player 2
    do_reset();
    park();
    for (int m = 0; m < 108; m++) begin
      bx = 487 - 4 * m;
      my = (m % 2 == 1) ? 367 : 362;
      set_mallets(bx + 20, my, 900, 60);
      frame();
      park();
      frame();
    end
    check_ball("goal_l.pre", 55, 362);
    frame();
    check_val("goal_l.pulse", int'(goal_pulse), 1);
    check_val("goal_l.s2", int'(s2), 1);
    check_val("goal_l.s1", int'(s1), 0);
    check_ball("goal_l.frozen", 55, 362);
    @(negedge clk_in);
    check_val("goal_l.pulse_end", int'(goal_pulse), 0);
    repeat (59) frame();
    check_ball("hold.59", 55, 362);
    frame();
    check_ball("hold.serve", 487, 362);
    frame();
    check_ball("serve.rest", 487, 362);

    // Seven right-side goals for player 1
    for (int g = 1; g <= 7; g++) begin
      for (int m = 0; m < 120; m++) begin
        bx = 487 + 4 * m;
        my = (m % 2 == 1) ? 367 : 362;
        set_mallets(bx - 20, my, 900, 60);
        frame();
        park();
        frame();
      end
      frame();
      check_val($sformatf("goal_r%0d.pulse", g), int'(goal_pulse), 1);
      check_val($sformatf("goal_r%0d.s1", g), int'(s1), g);
      check_val($sformatf("goal_r%0d.over_early", g), int'(game_over), 0);
      repeat (60) frame();
      check_val($sformatf("goal_r%0d.over", g), int'(game_over), (g == 7) ? 1 : 0);
      check_ball($sformatf("goal_r%0d.serve", g), 487, 362);
    end
    check_val("win.s2", int'(s2), 1);

    // Game over: contact and frames change nothing
    set_mallets(477, 372, 497, 352);
    repeat (3) frame();
    check_ball("over.ball", 487, 362);
    check_val("over.s1", int'(s1), 7);
    check_val("over.flag", int'(game_over), 1);
    check_val("over.goal", int'(goal_pulse), 0);

    do_reset();
    check_val("rst2.over", int'(game_over), 0);
    check_val("rst2.s1", int'(s1), 0);
    check_val("rst2.s2", int'(s2), 0);
    check_ball("rst2", 487, 362);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
